serial_link_transceiver: RTL
============================

Name: serial_link_transceiver

Overview:
- Parametrised full-duplex asynchronous serial transceiver: one transmitter (parallel-to-serial) and one receiver (serial-to-parallel) sharing a single clock.
- Bit timing is set by an oversampling counter.
- Frame format is configurable: data width, optional parity, 1 or 2 stop bits.
- Adds valid/ready transmit handshake, receive error flags and false-start rejection; sits between the node's parallel bus logic and the physical serial line.

Parameters:
DATA_BITS, 8, data bits per frame (5..16)
OVERSAMPLE, 16, clocks per serial bit (even, >=4)
PARITY_EN, 0, 1 = parity bit sent/checked after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  DATA_BITS  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  transmitter can accept a word
tx_busy  output  1  frame in progress on serial_out
serial_out  output  1  serial line out, idle high
serial_in  input  1  serial line in, asynchronous, idle high
rx_data  output  DATA_BITS  last received word
rx_valid  output  1  one-cycle pulse: rx_data/flags updated
rx_parity_err  output  1  parity mismatch on last frame
rx_frame_err  output  1  a stop bit sampled low on last frame
rx_busy  output  1  receiver mid-frame

Behaviour:
- Reset (reset=0, async): serial_out=1, tx_ready=1, tx_busy=0, rx_data=0, rx_valid=0, both error flags=0, rx_busy=0. All counters are cleared and both FSMs go to IDLE. Asserting reset mid-frame aborts the frame immediately; serial_out returns high.
- Frame order: start (0), data LSB first, parity (if PARITY_EN), STOP_BITS ones. F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits, each OVERSAMPLE clocks.
- Parity bit: XOR of data bits, inverted when PARITY_ODD=1.
- TX FSM IDLE->START->DATA->PARITY->STOP->IDLE. PARITY is skipped when PARITY_EN=0.
  - tx_ready=1 only in IDLE.
  - Transfer on rising edge with tx_valid&&tx_ready. tx_data is latched into the shift register at that edge; later tx_data changes are ignored.
  - serial_out is registered and goes low on the transfer edge. It holds each bit exactly OVERSAMPLE clocks.
  - tx_busy=1 from the transfer edge until the last stop bit completes. The FSM then spends one cycle in IDLE with tx_ready=1.
  - Back-to-back frames with tx_valid held high are therefore spaced F*OVERSAMPLE+1 clocks start-to-start.
  - tx_valid while not ready is ignored; it is not queued.
- RX input: 2-flop synchronizer on serial_in. Detection cycle T is the first cycle the synchronized value is 0 while the RX FSM is IDLE and armed.
- RX FSM IDLE->START->DATA->PARITY->STOP->IDLE.
  - Sample counter cleared at T. Start bit sampled at T+OVERSAMPLE/2.
  - If the start-bit sample is 1: false start; return to IDLE with no rx_valid and flags unchanged.
  - Bit k (k=1..F-1) sampled at T+OVERSAMPLE/2+k*OVERSAMPLE.
  - Data shifted in LSB first.
- RX completion:
  - On the cycle after the last stop-bit sample: rx_data, rx_parity_err and rx_frame_err update together and rx_valid=1 for exactly one cycle.
  - Flags hold until the next completed frame.
  - rx_parity_err is always 0 when PARITY_EN=0.
  - rx_frame_err=1 if any stop bit sampled 0; rx_data still updates.
- RX re-arm:
  - After any frame error, the receiver stays disarmed (IDLE, rx_busy=0) until the synchronized line has been 1 for at least one cycle. This prevents a held-low break from producing repeated frames.
  - After a good frame the receiver re-arms immediately.
- rx_busy=1 from T through the rx_valid cycle.
- No receive backpressure: a new frame overwrites rx_data.
- TX and RX are fully independent; simultaneous activity is allowed, including loopback.

Test Plan:
- Defaults, serial_out wired to serial_in; transfer 0x55 on edge A.
  - serial_out: 0 for clocks 0-15, then 1,0,1,0,1,0,1,0 (16 clocks each), then 1.
  - tx_ready returns at A+160.
  - rx_valid pulses once at A+155 with rx_data=0x55, both flags 0.
- Back-to-back: tx_valid held high with 0xA5 then 0x3C -> second start bit begins 161 clocks after the first; receiver outputs 0xA5 then 0x3C, two rx_valid pulses total.
- PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7: send 0x41.
  - Parity bit = 0 and frame length = 160 clocks.
  - Bench-injected frame with flipped parity -> rx_parity_err=1, rx_data=0x41.
- STOP_BITS=2: bench drives a frame with second stop bit 0 and the line then held low for 64 clocks -> one rx_valid with rx_frame_err=1; no further rx_valid until the line returns high.
- False start: serial_in low for 5 clocks, then high (OVERSAMPLE=16) -> no rx_valid, rx_busy drops after the start sample, flags unchanged.
- Reset mid-frame: assert reset during the 4th data bit of both TX and RX -> serial_out=1, tx_ready=1, rx_busy=0 immediately; the next full frame sent after release is received correctly.

Source files
------------

// File: rtl/serial_link_transceiver.sv
// serial_link_transceiver: oversampled full-duplex async serial TX/RX with
// configurable frame (data width, optional parity, 1 or 2 stop bits).
module serial_link_transceiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 serial_out,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF      = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               tx_state, rx_state;
    logic [CW-1:0]        tx_cnt, rx_cnt;
    logic [BW-1:0]        tx_bit, rx_bit;
    logic [DATA_BITS-1:0] tx_shift, rx_shift;
    logic                 tx_par, rx_par, stop_err, armed, sample, line;
    logic [1:0]           sync;

    assign line    = sync[1];
    assign sample  = (rx_state == START) ? (rx_cnt == HALF) : (rx_cnt == BIT_END);
    assign rx_busy = (rx_state != IDLE) || rx_valid || (armed && !line);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            tx_cnt <= (tx_state == IDLE || tx_cnt == BIT_END) ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                IDLE: if (tx_valid) begin
                    tx_shift   <= tx_data;
                    tx_par     <= ^tx_data ^ ODD;
                    serial_out <= 1'b0;
                    tx_ready   <= 1'b0;
                    tx_busy    <= 1'b1;
                    tx_state   <= START;
                end
                START: if (tx_cnt == BIT_END) begin
                    serial_out <= tx_shift[0];
                    tx_shift   <= tx_shift >> 1;
                    tx_bit     <= '0;
                    tx_state   <= DATA;
                end
                DATA: if (tx_cnt == BIT_END) begin
                    if (tx_bit == LAST_DATA) begin
                        tx_bit     <= '0;
                        serial_out <= (PARITY_EN != 0) ? tx_par : 1'b1;
                        tx_state   <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        serial_out <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit     <= tx_bit + 1'b1;
                    end
                end
                PARITY: if (tx_cnt == BIT_END) begin
                    serial_out <= 1'b1;
                    tx_state   <= STOP;
                end
                STOP: if (tx_cnt == BIT_END) begin
                    if (tx_bit == LAST_STOP) begin
                        tx_state <= IDLE;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync          <= 2'b11;
            rx_state      <= IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            stop_err      <= 1'b0;
            armed         <= 1'b1;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            sync     <= {sync[0], serial_in};
            rx_valid <= 1'b0;
            rx_cnt   <= (rx_state == IDLE || sample) ? '0 : rx_cnt + 1'b1;
            case (rx_state)
                IDLE: begin
                    if (line) armed <= 1'b1;
                    if (armed && !line) begin
                        stop_err <= 1'b0;
                        rx_state <= START;
                    end
                end
                START: if (sample) begin
                    rx_bit   <= '0;
                    rx_state <= line ? IDLE : DATA;
                end
                DATA: if (sample) begin
                    rx_shift <= {line, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= (rx_bit == LAST_DATA) ? '0 : rx_bit + 1'b1;
                    if (rx_bit == LAST_DATA) rx_state <= (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (sample) begin
                    rx_par   <= line;
                    rx_state <= STOP;
                end
                STOP: if (sample) begin
                    if (rx_bit == LAST_STOP) begin
                        rx_state      <= IDLE;
                        rx_valid      <= 1'b1;
                        rx_data       <= rx_shift;
                        rx_parity_err <= (PARITY_EN != 0) && (rx_par != (^rx_shift ^ ODD));
                        rx_frame_err  <= stop_err | !line;
                        // a bad stop bit may be a held break: wait for the line to go high
                        armed         <= !(stop_err | !line);
                    end else begin
                        stop_err <= stop_err | !line;
                        rx_bit   <= rx_bit + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule
